// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the pipelined ALU.
//   operation_t : 4-bit opcode encoding (codes above OP_PASSB are reserved)
//   FLG_*       : bit positions of the flags inside the {N,Z,C,V} nibble
//   alu_flags_t : packed {n,z,c,v} status flags
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_SRA   = 4'd8,
    OP_PASSB = 4'd9
  } operation_t;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
//   op    in  4      opcode (operation_t encoding, reserved codes flagged)
//   a     in  WIDTH  operand A
//   b     in  WIDTH  operand B / shift amount
//   res   out WIDTH  result
//   flags out 4      {N,Z,C,V}
//   err   out 1      reserved opcode
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output alu_flags_t       flags,
  output logic             err
);

  localparam int               SH_W  = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

  logic                    is_sub;
  logic [WIDTH-1:0]        b_op;
  logic [WIDTH:0]          sum;
  logic                    add_v;
  logic [SH_W-1:0]         amt;
  logic                    sh_big;
  logic signed [WIDTH-1:0] sra_res;

  // SUB shares the adder: a + ~b + 1, so carry-out means "no borrow".
  assign is_sub = (op == OP_SUB);
  assign b_op   = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
  assign add_v  = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  // The low bits select the shift; the whole of b decides whether the
  // operand is shifted out completely (e.g. 9 on an 8-bit ALU gives 0).
  assign amt     = b[SH_W-1:0];
  assign sh_big  = (b >= W_LIM);
  // Kept in its own signed net so the arithmetic shift is not turned
  // logical by an unsigned ternary context.
  assign sra_res = $signed(a) >>> amt;

  always_comb begin
    res   = '0;
    flags = '0;
    err   = 1'b0;
    case (op)
      OP_NOP: ;
      OP_ADD, OP_SUB: begin
        res     = sum[WIDTH-1:0];
        flags.c = sum[WIDTH];
        flags.v = add_v;
      end
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_SHL:   res = sh_big ? '0 : (a << amt);
      OP_SHR:   res = sh_big ? '0 : (a >> amt);
      OP_SRA:   res = sh_big ? {WIDTH{a[WIDTH-1]}} : sra_res;
      OP_PASSB: res = b;
      default:  err = 1'b1;
    endcase
    // N/Z reflect the result for every legal op except NOP.
    if (!err && (op != OP_NOP)) begin
      flags.n = res[WIDTH-1];
      flags.z = (res == '0);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined integer ALU with valid/ready flow control.
//   clk, rst_n             clock, async active-low reset
//   op_in/a_in/b_in/tag_in request fields, accepted on in_valid && in_ready
//   in_ready               global advance (no dependency on in_valid)
//   out/out_flags/out_err  result of the last stage, with its tag on out_tag
//   out_valid/out_ready    result handshake
// Stage 0 registers the request, the core computes into stage 1, stages
// 2..STAGES-1 are plain delays. The whole pipe moves or holds as one, so
// bubbles stay in place while the consumer stalls.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output alu_flags_t       out_flags,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    alu_flags_t       flags;
    logic             err;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic              adv;
  logic              acc;
  logic [STAGES-1:0] vld_q;
  // vld_pipe[0] is this cycle's accept, vld_pipe[k] is the valid of stage k-1.
  logic [STAGES:0]   vld_pipe;
  req_t              req_q;
  rsp_t              rsp_d;
  rsp_t              rsp_q [1:STAGES-1];
  logic [WIDTH-1:0]  core_res;
  alu_flags_t        core_flags;
  logic              core_err;

  assign adv      = !vld_q[STAGES-1] || out_ready;
  assign in_ready = adv;
  assign acc      = in_valid && adv;
  assign vld_pipe = {vld_q, acc};

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op    (req_q.op),
    .a     (req_q.a),
    .b     (req_q.b),
    .res   (core_res),
    .flags (core_flags),
    .err   (core_err)
  );

  assign rsp_d = '{res: core_res, flags: core_flags, err: core_err, tag: req_q.tag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      req_q <= '0;
      for (int k = 1; k < STAGES; k++) rsp_q[k] <= '0;
    end else if (adv) begin
      vld_q    <= vld_pipe[STAGES-1:0];
      req_q    <= '{op: op_in, a: a_in, b: b_in, tag: tag_in};
      rsp_q[1] <= rsp_d;
      for (int k = 2; k < STAGES; k++) rsp_q[k] <= rsp_q[k-1];
    end
  end

  assign out       = rsp_q[STAGES-1].res;
  assign out_flags = rsp_q[STAGES-1].flags;
  assign out_err   = rsp_q[STAGES-1].err;
  assign out_tag   = rsp_q[STAGES-1].tag;
  assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench. dut2 is the default 2-stage build,
// dut4 a 4-stage build used for latency and the random scoreboard run.
module tb_alu_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [3:0] op2, tg2_in, fl2, tg2;
  logic [7:0] a2, b2, out2;
  logic       iv2, ir2, ov2, or2, er2;

  logic [3:0] op4, tg4_in, fl4, tg4;
  logic [7:0] a4, b4, out4;
  logic       iv4, ir4, ov4, or4, er4;

  alu_pipe #(.WIDTH(8), .STAGES(2), .TAG_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .op_in(op2), .a_in(a2), .b_in(b2), .tag_in(tg2_in),
    .in_valid(iv2), .in_ready(ir2), .out(out2), .out_flags(fl2), .out_err(er2),
    .out_tag(tg2), .out_valid(ov2), .out_ready(or2)
  );

  alu_pipe #(.WIDTH(8), .STAGES(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .op_in(op4), .a_in(a4), .b_in(b4), .tag_in(tg4_in),
    .in_valid(iv4), .in_ready(ir4), .out(out4), .out_flags(fl4), .out_err(er4),
    .out_tag(tg4), .out_valid(ov4), .out_ready(or4)
  );

  // Reference model in plain integer arithmetic: returns {res, N, Z, C, V, err}.
  function automatic logic [12:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, s;
    logic [7:0] r;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    c = 1'b0; v = 1'b0; r = 8'h00;
    case (op)
      4'd0: return 13'h0;
      4'd1: begin s = ua + ub; r = s[7:0]; c = (s > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      4'd2: begin s = ua - ub; r = s[7:0]; c = (ua >= ub); v = (sa - sb > 127) || (sa - sb < -128); end
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: begin s = ua << ub; r = (ub >= 8) ? 8'h00 : s[7:0]; end
      4'd7: begin s = ua >> ub; r = (ub >= 8) ? 8'h00 : s[7:0]; end
      4'd8: begin s = sa >>> ((ub >= 8) ? 7 : ub); r = s[7:0]; end
      4'd9: r = b;
      default: return 13'h1;
    endcase
    return {r, r[7], (r == 8'h00), c, v, 1'b0};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    op2 = '0; a2 = '0; b2 = '0; tg2_in = '0; iv2 = 1'b0; or2 = 1'b1;
    op4 = '0; a4 = '0; b4 = '0; tg4_in = '0; iv4 = 1'b0; or4 = 1'b1;
    #12;
    checks++;
    if ({ov2, out2, fl2, er2, tg2} !== 18'h0) begin
      failures++; $display("FAIL reset_dut2: got %h expected 0", {ov2, out2, fl2, er2, tg2});
    end
    checks++;
    if ({ov4, out4, fl4, er4, tg4} !== 18'h0) begin
      failures++; $display("FAIL reset_dut4: got %h expected 0", {ov4, out4, fl4, er4, tg4});
    end
    checks++;
    if ({ir2, ir4} !== 2'b11) begin
      failures++; $display("FAIL reset_ready: got %b expected 11", {ir2, ir4});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Directed single ops: {op, a, b, tag, res, {N,Z,C,V}, err}.
  task automatic test_single_ops();
    logic [36:0] tbl [0:16];
    logic [3:0] op, tag, efl;
    logic [7:0] a, b, eres;
    logic       eerr;
    tbl[0]  = {4'd1,  8'h05, 8'h03, 4'h7, 8'h08, 4'b0000, 1'b0};
    tbl[1]  = {4'd2,  8'h03, 8'h05, 4'h1, 8'hFE, 4'b1000, 1'b0};
    tbl[2]  = {4'd2,  8'h05, 8'h05, 4'h2, 8'h00, 4'b0110, 1'b0};
    tbl[3]  = {4'd1,  8'h7F, 8'h01, 4'h3, 8'h80, 4'b1001, 1'b0};
    tbl[4]  = {4'd1,  8'hFF, 8'h01, 4'h4, 8'h00, 4'b0110, 1'b0};
    tbl[5]  = {4'd8,  8'h80, 8'h03, 4'h5, 8'hF0, 4'b1000, 1'b0};
    tbl[6]  = {4'd6,  8'h01, 8'h09, 4'h6, 8'h00, 4'b0100, 1'b0};
    tbl[7]  = {4'd3,  8'hF0, 8'h3C, 4'h8, 8'h30, 4'b0000, 1'b0};
    tbl[8]  = {4'd4,  8'hF0, 8'h0C, 4'h9, 8'hFC, 4'b1000, 1'b0};
    tbl[9]  = {4'd5,  8'hFF, 8'h0F, 4'hA, 8'hF0, 4'b1000, 1'b0};
    tbl[10] = {4'd7,  8'h80, 8'h07, 4'hB, 8'h01, 4'b0000, 1'b0};
    tbl[11] = {4'd8,  8'h80, 8'h09, 4'hC, 8'hFF, 4'b1000, 1'b0};
    tbl[12] = {4'd9,  8'h12, 8'h85, 4'hD, 8'h85, 4'b1000, 1'b0};
    tbl[13] = {4'd0,  8'h05, 8'h05, 4'hE, 8'h00, 4'b0000, 1'b0};
    tbl[14] = {4'd12, 8'h01, 8'h01, 4'hF, 8'h00, 4'b0000, 1'b1};
    tbl[15] = {4'd1,  8'h01, 8'h01, 4'h0, 8'h02, 4'b0000, 1'b0};
    tbl[16] = {4'd2,  8'h80, 8'h01, 4'h1, 8'h7F, 4'b0011, 1'b0};
    or2 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      {op, a, b, tag, eres, efl, eerr} = tbl[i];
      @(negedge clk);
      op2 = op; a2 = a; b2 = b; tg2_in = tag; iv2 = 1'b1;
      @(negedge clk);
      iv2 = 1'b0;
      checks++;
      if (ov2 !== 1'b0) begin
        failures++; $display("FAIL op%0d_early: out_valid=%b expected 0", i, ov2);
      end
      @(negedge clk);
      checks++;
      if ({ov2, out2, fl2, er2, tg2} !== {1'b1, eres, efl, eerr, tag}) begin
        failures++;
        $display("FAIL op%0d (op=%0d a=%h b=%h): got v=%b res=%h fl=%b err=%b tag=%h expected v=1 res=%h fl=%b err=%b tag=%h",
                 i, op, a, b, ov2, out2, fl2, er2, tg2, eres, efl, eerr, tag);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] q[$];
    logic [16:0] exp, held;
    logic        hold_v = 1'b0;
    logic        exp_rdy;
    int sent = 0, rcvd = 0;
    for (int c = 0; c < 40 && rcvd < 6; c++) begin
      @(negedge clk);
      or2 = !(c >= 2 && c <= 4);
      if (sent < 6) begin
        op2 = 4'($urandom_range(1, 9)); a2 = 8'($urandom); b2 = 8'($urandom_range(0, 12));
        tg2_in = 4'(sent); iv2 = 1'b1;
      end else iv2 = 1'b0;
      #1;
      exp_rdy = !(c >= 2 && c <= 4);
      checks++;
      if (ir2 !== exp_rdy) begin
        failures++; $display("FAIL b2b_ready c%0d: got %b expected %b", c, ir2, exp_rdy);
      end
      if (ov2 && !or2) begin
        if (hold_v) begin
          checks++;
          if ({out2, fl2, er2, tg2} !== held) begin
            failures++; $display("FAIL b2b_hold c%0d: got %h expected %h", c, {out2, fl2, er2, tg2}, held);
          end
        end
        held = {out2, fl2, er2, tg2}; hold_v = 1'b1;
      end else hold_v = 1'b0;
      if (ov2 && or2) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL b2b_extra c%0d: got result %h expected none", c, {out2, fl2, er2, tg2});
        end else begin
          exp = q.pop_front();
          if ({out2, fl2, er2, tg2} !== exp) begin
            failures++; $display("FAIL b2b_data c%0d: got %h expected %h", c, {out2, fl2, er2, tg2}, exp);
          end
        end
        rcvd++;
      end
      if (iv2 && ir2) begin
        q.push_back({model(op2, a2, b2), tg2_in});
        sent++;
      end
    end
    iv2 = 1'b0; or2 = 1'b1;
    checks++;
    if (rcvd != 6 || q.size() != 0) begin
      failures++; $display("FAIL b2b_count: got %0d results expected 6", rcvd);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (ov2 !== 1'b0) begin
        failures++; $display("FAIL b2b_dup c%0d: out_valid=%b expected 0", c, ov2);
      end
    end
  endtask

  task automatic test_reset_midstream();
    or2 = 1'b1;
    @(negedge clk); op2 = 4'd1; a2 = 8'd10; b2 = 8'd20; tg2_in = 4'h3; iv2 = 1'b1;
    @(negedge clk); op2 = 4'd1; a2 = 8'd30; b2 = 8'd40; tg2_in = 4'h4;
    @(negedge clk); iv2 = 1'b0;
    checks++;
    if ({ov2, out2} !== {1'b1, 8'd30}) begin
      failures++; $display("FAIL rst_pre: got v=%b res=%h expected v=1 res=1e", ov2, out2);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ov2, out2, fl2, er2, tg2} !== 18'h0) begin
      failures++; $display("FAIL rst_async: got %h expected 0", {ov2, out2, fl2, er2, tg2});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (ov2 !== 1'b0) begin
        failures++; $display("FAIL rst_flushed c%0d: out_valid=%b expected 0", c, ov2);
      end
    end
    @(negedge clk); op2 = 4'd1; a2 = 8'd1; b2 = 8'd2; tg2_in = 4'h9; iv2 = 1'b1;
    @(negedge clk); iv2 = 1'b0;
    @(negedge clk);
    checks++;
    if ({ov2, out2, fl2, er2, tg2} !== {1'b1, 8'd3, 4'b0000, 1'b0, 4'h9}) begin
      failures++; $display("FAIL rst_after: got v=%b res=%h fl=%b tag=%h expected v=1 res=03 fl=0000 tag=9", ov2, out2, fl2, tg2);
    end
  endtask

  task automatic test_latency4();
    logic [7:0] a, b;
    or4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      @(negedge clk); op4 = 4'd5; a4 = a; b4 = b; tg4_in = 4'(i + 2); iv4 = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        iv4 = 1'b0;
        checks++;
        if (k < 4) begin
          if (ov4 !== 1'b0) begin
            failures++; $display("FAIL lat4_%0d edge%0d: out_valid=%b expected 0", i, k, ov4);
          end
        end else if ({ov4, out4, tg4} !== {1'b1, a ^ b, 4'(i + 2)}) begin
          failures++; $display("FAIL lat4_%0d: got v=%b res=%h tag=%h expected v=1 res=%h tag=%h", i, ov4, out4, tg4, a ^ b, 4'(i + 2));
        end
      end
    end
  endtask

  task automatic test_random4();
    logic [16:0] q[$];
    logic [16:0] exp;
    int sent = 0;
    for (int c = 0; c < 4000 && (sent < 300 || q.size() > 0); c++) begin
      @(negedge clk);
      or4 = ($urandom_range(0, 3) != 0);
      if (sent < 300 && $urandom_range(0, 4) != 0) begin
        op4 = 4'($urandom_range(0, 15)); a4 = 8'($urandom);
        b4 = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
        tg4_in = 4'($urandom); iv4 = 1'b1;
      end else iv4 = 1'b0;
      #1;
      if (ov4 && or4) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL rnd_extra c%0d: got %h expected none", c, {out4, fl4, er4, tg4});
        end else begin
          exp = q.pop_front();
          if ({out4, fl4, er4, tg4} !== exp) begin
            failures++; $display("FAIL rnd_data c%0d: got %h expected %h", c, {out4, fl4, er4, tg4}, exp);
          end
        end
      end
      if (iv4 && ir4) begin
        q.push_back({model(op4, a4, b4), tg4_in});
        sent++;
      end
    end
    iv4 = 1'b0; or4 = 1'b1;
    checks++;
    if (sent != 300 || q.size() != 0) begin
      failures++; $display("FAIL rnd_timeout: sent %0d pending %0d expected 300 and 0", sent, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_back_to_back();
    test_reset_midstream();
    test_latency4();
    test_random4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
